// File: rtl/rotor_step_controller.sv
// ---------------------------------------------------------------------------
// rotor_step_controller
//
// Keyboard-to-datapath sequencer for a three-rotor letter encoder. A single
// one-hot key press steps the rotors once (with the classic middle-rotor
// double step), then hands the letter to the rotor/reflector datapath. The
// result comes back through a request/acknowledge handshake. Each press
// yields exactly one encode; the key must be released before the next one.
//
// Ports
//   clk       in   1  clock, rising edge
//   rst_n     in   1  asynchronous active-low reset
//   key_dec   in  26  one-hot keyboard, bit n = letter n, zero = no key
//   load      in   1  load rotor start positions (honoured only in IDLE)
//   pos_in    in  15  {left[14:10], middle[9:5], right[4:0]} start positions
//   enc_req   out  1  request to the datapath (high throughout ENCODE)
//   enc_let   out  5  letter presented with enc_req, 0 otherwise
//   enc_ack   in   1  datapath accepts the request, enc_res valid
//   enc_res   in   5  encoded letter from the datapath
//   pos_l/m/r out  5  current rotor positions (0..25)
//   out_let   out  5  last encoded letter
//   out_valid out  1  one-cycle pulse when out_let updates
//   busy      out  1  high in any state other than IDLE
// ---------------------------------------------------------------------------
module rotor_step_controller #(
  parameter logic [4:0] NOTCH_R = 5'd16,
  parameter logic [4:0] NOTCH_M = 5'd4,
  parameter logic [4:0] NOTCH_L = 5'd21
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [25:0] key_dec,
  input  logic        load,
  input  logic [14:0] pos_in,
  output logic        enc_req,
  output logic [4:0]  enc_let,
  input  logic        enc_ack,
  input  logic [4:0]  enc_res,
  output logic [4:0]  pos_l,
  output logic [4:0]  pos_m,
  output logic [4:0]  pos_r,
  output logic [4:0]  out_let,
  output logic        out_valid,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, STEP, ENCODE, RELEASE} state_t;

  state_t      state_reg, state_next;
  logic [4:0]  letter_reg;
  logic [4:0]  pos_l_reg, pos_m_reg, pos_r_reg;
  logic [4:0]  out_let_reg;
  logic        out_valid_reg;

  logic        key_onehot;
  logic [4:0]  key_idx;
  logic        step_m, step_l;

  // The left rotor's notch never drives any stepping; it is kept only so the
  // parameter set describes the full machine.
  logic        unused_notch_l;
  assign unused_notch_l = ^NOTCH_L;

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
  assign key_onehot = (key_dec != 26'd0) && ((key_dec & (key_dec - 26'd1)) == 26'd0);

  always_comb begin
    key_idx = 5'd0;
    for (int i = 0; i < 26; i++) begin
      if (key_dec[i]) key_idx = 5'(i);
    end
  end

  // Both decisions look at pre-step positions; the middle rotor advances on
  // its own notch too, which produces the double step.
  assign step_m = (pos_r_reg == NOTCH_R) || (pos_m_reg == NOTCH_M);
  assign step_l = (pos_m_reg == NOTCH_M);

  function automatic logic [4:0] inc26(input logic [4:0] v);
    return (v >= 5'd25) ? 5'd0 : v + 5'd1;
  endfunction

  function automatic logic [4:0] clamp_load(input logic [4:0] v);
    return (v > 5'd25) ? 5'd0 : v;
  endfunction

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic; load in IDLE takes priority over a key
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (!load && key_onehot) state_next = STEP;
      STEP:    state_next = ENCODE;
      ENCODE:  if (enc_ack) state_next = RELEASE;
      RELEASE: if (key_dec == 26'd0) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy    = (state_reg != IDLE);
    enc_req = (state_reg == ENCODE);
    enc_let = (state_reg == ENCODE) ? letter_reg : 5'd0;
  end

  // Datapath registers: letter capture, rotor positions, result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      letter_reg    <= 5'd0;
      pos_l_reg     <= 5'd0;
      pos_m_reg     <= 5'd0;
      pos_r_reg     <= 5'd0;
      out_let_reg   <= 5'd0;
      out_valid_reg <= 1'b0;
    end else begin
      out_valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (load) begin
            pos_l_reg <= clamp_load(pos_in[14:10]);
            pos_m_reg <= clamp_load(pos_in[9:5]);
            pos_r_reg <= clamp_load(pos_in[4:0]);
          end else if (key_onehot) begin
            letter_reg <= key_idx;
          end
        end
        STEP: begin
          pos_r_reg <= inc26(pos_r_reg);
          if (step_m) pos_m_reg <= inc26(pos_m_reg);
          if (step_l) pos_l_reg <= inc26(pos_l_reg);
        end
        ENCODE: begin
          if (enc_ack) begin
            out_let_reg   <= enc_res;
            out_valid_reg <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign pos_l     = pos_l_reg;
  assign pos_m     = pos_m_reg;
  assign pos_r     = pos_r_reg;
  assign out_let   = out_let_reg;
  assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_rotor_step_controller.sv
module tb_rotor_step_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [25:0] key_dec = '0;
  logic        load = 1'b0;
  logic [14:0] pos_in = '0;
  logic        enc_ack = 1'b0;
  logic [4:0]  enc_res = '0;
  logic        enc_req;
  logic [4:0]  enc_let;
  logic [4:0]  pos_l, pos_m, pos_r;
  logic [4:0]  out_let;
  logic        out_valid;
  logic        busy;

  rotor_step_controller dut (
    .clk(clk), .rst_n(rst_n), .key_dec(key_dec), .load(load), .pos_in(pos_in),
    .enc_req(enc_req), .enc_let(enc_let), .enc_ack(enc_ack), .enc_res(enc_res),
    .pos_l(pos_l), .pos_m(pos_m), .pos_r(pos_r),
    .out_let(out_let), .out_valid(out_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int pulse_cnt = 0;
  int exp_pulses = 0;

  // Reference model: rotor positions as plain integers 0..25
  int ml = 0, mm = 0, mr = 0, mout = 0;

  always @(posedge clk) if (out_valid === 1'b1) pulse_cnt <= pulse_cnt + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic check_pos(input string tag);
    check({tag, ".pos_l"}, pos_l, ml);
    check({tag, ".pos_m"}, pos_m, mm);
    check({tag, ".pos_r"}, pos_r, mr);
  endtask

  function automatic int clamp26(input int f);
    return (f > 25) ? 0 : f;
  endfunction

  // One key press on the machine: right always turns, middle on right notch
  // or its own notch, left on middle notch, all judged before turning.
  task automatic model_step();
    bit mid_turn, left_turn;
    mid_turn  = (mr == 16) || (mm == 4);
    left_turn = (mm == 4);
    mr = (mr + 1) % 26;
    if (mid_turn)  mm = (mm + 1) % 26;
    if (left_turn) ml = (ml + 1) % 26;
  endtask

  // All tasks are entered at a negedge; inputs change there, outputs are
  // sampled at later negedges.
  task automatic do_load(input logic [14:0] p);
    load = 1'b1;
    pos_in = p;
    @(negedge clk);
    load = 1'b0;
    ml = clamp26(int'(p[14:10]));
    mm = clamp26(int'(p[9:5]));
    mr = clamp26(int'(p[4:0]));
    check("load.busy", busy, 0);
    check_pos("load");
    $display("load pos_in=%0d/%0d/%0d -> L=%0d M=%0d R=%0d", p[14:10], p[9:5], p[4:0], pos_l, pos_m, pos_r);
  endtask

  task automatic idle_invalid(input logic [25:0] k, input int n);
    key_dec = k;
    enc_ack = 1'($urandom_range(0, 1));
    repeat (n) begin
      @(negedge clk);
      check("inv.busy", busy, 0);
      check("inv.enc_req", enc_req, 0);
      check("inv.enc_let", enc_let, 0);
      check("inv.out_valid", out_valid, 0);
      check_pos("inv");
    end
    key_dec = '0;
    enc_ack = 1'b0;
    $display("ignored key=%h for %0d cycles", k, n);
  endtask

  task automatic press(input int letter, input int delay, input logic [4:0] res,
                       input int hold, input bit load_rel, input logic [14:0] lpos);
    key_dec = 26'd1 << letter;
    enc_ack = 1'b0;
    @(negedge clk);                       // key accepted -> STEP
    check("step.busy", busy, 1);
    check("step.enc_req", enc_req, 0);
    check("step.out_valid", out_valid, 0);
    model_step();
    @(negedge clk);                       // ENCODE
    check("enc.enc_req", enc_req, 1);
    check("enc.enc_let", enc_let, letter);
    check_pos("enc");
    for (int d = 0; d < delay; d++) begin
      enc_res = 5'($urandom_range(0, 25));
      @(negedge clk);
      check("wait.enc_req", enc_req, 1);
      check("wait.enc_let", enc_let, letter);
      check("wait.out_valid", out_valid, 0);
    end
    enc_ack = 1'b1;
    enc_res = res;
    @(negedge clk);
    enc_ack = 1'b0;
    mout = int'(res);
    exp_pulses++;
    check("ack.out_valid", out_valid, 1);
    check("ack.out_let", out_let, mout);
    check("ack.enc_req", enc_req, 0);
    check("ack.enc_let", enc_let, 0);
    check("ack.busy", busy, 1);
    if (load_rel) begin
      load = 1'b1;
      pos_in = lpos;
      @(negedge clk);
      load = 1'b0;
      check_pos("rel_load");
      check("rel_load.busy", busy, 1);
      check("rel_load.out_valid", out_valid, 0);
    end
    for (int h = 0; h < hold; h++) begin
      if ($urandom_range(0, 3) == 0) key_dec = 26'd1 << $urandom_range(0, 25);
      @(negedge clk);
      check("hold.out_valid", out_valid, 0);
      check("hold.busy", busy, 1);
      check("hold.enc_req", enc_req, 0);
    end
    key_dec = '0;
    @(negedge clk);
    check("rel.busy", busy, 0);
    check("rel.out_valid", out_valid, 0);
    check("pulses", pulse_cnt, exp_pulses);
    $display("press letter=%0d delay=%0d res=%0d -> L=%0d M=%0d R=%0d out=%0d",
             letter, delay, res, pos_l, pos_m, pos_r, out_let);
  endtask

  task automatic check_triple(input string tag, input int l, input int m, input int r);
    check({tag, ".L"}, pos_l, l);
    check({tag, ".M"}, pos_m, m);
    check({tag, ".R"}, pos_r, r);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst.busy", busy, 0);
    check("rst.enc_req", enc_req, 0);
    check("rst.enc_let", enc_let, 0);
    check("rst.out_valid", out_valid, 0);
    check("rst.out_let", out_let, 0);
    check_pos("rst");
    rst_n = 1'b1;
    @(negedge clk);

    // Letter 0, immediate ack, result 9
    press(0, 0, 5'd9, 2, 1'b0, '0);
    check("basic.pos_r", pos_r, 1);
    check("basic.out_let", out_let, 9);

    // Multi-hot and no-key are ignored
    idle_invalid(26'h3, 10);
    idle_invalid(26'h0, 10);

    // Double step sequence
    do_load({5'd0, 5'd3, 5'd16});
    press(4, 0, 5'd1, 0, 1'b0, '0);
    check_triple("ds1", 0, 4, 17);
    press(5, 1, 5'd2, 0, 1'b0, '0);
    check_triple("ds2", 1, 5, 18);
    press(6, 0, 5'd3, 0, 1'b0, '0);
    check_triple("ds3", 1, 5, 19);

    // Wrap boundaries
    do_load({5'd25, 5'd25, 5'd25});
    press(25, 0, 5'd25, 0, 1'b0, '0);
    check_triple("wrap1", 25, 25, 0);
    do_load({5'd0, 5'd25, 5'd16});
    press(12, 0, 5'd0, 0, 1'b0, '0);
    check_triple("wrap2", 0, 0, 17);

    // Out-of-range fields load as zero
    do_load({5'd31, 5'd26, 5'd30});
    check_triple("clamp", 0, 0, 0);

    // Slow acknowledge, long hold, load during release
    press(17, 5, 5'd11, 20, 1'b1, {5'd2, 5'd2, 5'd2});

    // Load and key together: load wins, key taken afterwards
    key_dec = 26'd1 << 8;
    do_load({5'd7, 5'd8, 5'd9});
    press(8, 0, 5'd20, 1, 1'b0, '0);

    // Reset during ENCODE
    key_dec = 26'd1 << 7;
    @(negedge clk);
    @(negedge clk);
    check("pre_rst.enc_req", enc_req, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst.enc_req", enc_req, 0);
    check("mid_rst.enc_let", enc_let, 0);
    check("mid_rst.busy", busy, 0);
    check("mid_rst.out_let", out_let, 0);
    ml = 0; mm = 0; mr = 0; mout = 0;
    check_pos("mid_rst");
    @(negedge clk);
    rst_n = 1'b1;
    check("mid_rst.pulses", pulse_cnt, exp_pulses);
    press(7, 2, 5'd14, 0, 1'b0, '0);

    // Randomised traffic against the model
    for (int t = 0; t < 40; t++) begin
      int op;
      op = int'($urandom_range(0, 4));
      case (op)
        0: do_load(15'($urandom()));
        1, 2: press(int'($urandom_range(0, 25)), int'($urandom_range(0, 6)),
                    5'($urandom_range(0, 25)), int'($urandom_range(0, 4)),
                    1'($urandom_range(0, 1)), 15'($urandom()));
        3: begin
          int k;
          k = int'($urandom_range(0, 25));
          key_dec = 26'd1 << k;
          do_load(15'($urandom()));
          press(k, int'($urandom_range(0, 3)), 5'($urandom_range(0, 25)), 0, 1'b0, '0);
        end
        default: begin
          int a, b;
          logic [25:0] k2;
          a = int'($urandom_range(0, 25));
          b = (a + 1 + int'($urandom_range(0, 24))) % 26;
          k2 = (26'd1 << a) | (26'd1 << b);
          idle_invalid(k2, int'($urandom_range(1, 4)));
        end
      endcase
    end

    check("final.pulses", pulse_cnt, exp_pulses);
    check("final.out_let", out_let, mout);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
